// File: rtl/pipeline_probe.sv
// Serial probe: captures one channel word on request and shifts out MARK, channel id, data, then a GAP cycle.
// Optional even-parity bit after the data is enabled by defining PROBE_PARITY_EN.
module pipeline_probe #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 2,
    parameter int CSEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [CHANNELS*WIDTH-1:0]  ch_data,
    input  logic [CSEL_W-1:0]          ch_sel,
    input  logic                       start,
    input  logic                       cont,
    output logic                       ser_out,
    output logic                       ser_valid,
    output logic                       busy,
    output logic                       frame_done
);

    localparam int CNT_MAX = (WIDTH > CSEL_W) ? WIDTH : CSEL_W;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MARK,
        S_CHAN,
        S_DATA,
`ifdef PROBE_PARITY_EN
        S_PAR,
`endif
        S_GAP
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [CSEL_W-1:0]  r_chan_q;
    logic [WIDTH-1:0]   r_shift;
    logic               r_ser_out;
    logic               r_ser_valid;
    logic               r_busy;
    logic               r_frame_done;
`ifdef PROBE_PARITY_EN
    logic               r_par;
`endif

    logic [WIDTH-1:0]   w_sel_word;
    logic [CSEL_W-1:0]  w_chan_eff;
    logic               w_load;

    // Out-of-range selects yield an all-zero word.
    always_comb begin
        w_sel_word = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (32'(ch_sel) == k) begin
                w_sel_word = ch_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // A single-channel probe always sends channel id 0.
    assign w_chan_eff = (CHANNELS == 1) ? '0 : ch_sel;
    assign w_load     = ((r_state == S_IDLE) && start) || ((r_state == S_GAP) && cont);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_chan_q     <= '0;
            r_shift      <= '0;
            r_ser_out    <= 1'b0;
            r_ser_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
`ifdef PROBE_PARITY_EN
            r_par        <= 1'b0;
`endif
        end else begin
            r_frame_done <= 1'b0;
            if (w_load) begin
                r_state     <= S_MARK;
                r_chan_q    <= w_chan_eff;
                r_shift     <= w_sel_word;
                r_cnt       <= '0;
                r_ser_out   <= 1'b1;
                r_ser_valid <= 1'b1;
                r_busy      <= 1'b1;
`ifdef PROBE_PARITY_EN
                r_par       <= (^w_chan_eff) ^ (^w_sel_word);
`endif
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_ser_out   <= 1'b0;
                        r_ser_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                    S_MARK: begin
                        r_state   <= S_CHAN;
                        r_ser_out <= r_chan_q[CSEL_W-1];
                        r_chan_q  <= r_chan_q << 1;
                        r_cnt     <= CNT_W'(CSEL_W - 1);
                    end
                    S_CHAN: begin
                        if (r_cnt == '0) begin
                            r_state   <= S_DATA;
                            r_ser_out <= r_shift[WIDTH-1];
                            r_shift   <= r_shift << 1;
                            r_cnt     <= CNT_W'(WIDTH - 1);
                        end else begin
                            r_ser_out <= r_chan_q[CSEL_W-1];
                            r_chan_q  <= r_chan_q << 1;
                            r_cnt     <= r_cnt - CNT_W'(1);
                        end
                    end
                    S_DATA: begin
                        if (r_cnt == '0) begin
`ifdef PROBE_PARITY_EN
                            r_state   <= S_PAR;
                            r_ser_out <= r_par;
`else
                            r_state      <= S_GAP;
                            r_ser_out    <= 1'b0;
                            r_ser_valid  <= 1'b0;
                            r_frame_done <= 1'b1;
`endif
                        end else begin
                            r_ser_out <= r_shift[WIDTH-1];
                            r_shift   <= r_shift << 1;
                            r_cnt     <= r_cnt - CNT_W'(1);
                        end
                    end
`ifdef PROBE_PARITY_EN
                    S_PAR: begin
                        r_state      <= S_GAP;
                        r_ser_out    <= 1'b0;
                        r_ser_valid  <= 1'b0;
                        r_frame_done <= 1'b1;
                    end
`endif
                    S_GAP: begin
                        r_state     <= S_IDLE;
                        r_ser_out   <= 1'b0;
                        r_ser_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                    default: begin
                        r_state     <= S_IDLE;
                        r_ser_out   <= 1'b0;
                        r_ser_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ser_out    = r_ser_out;
    assign ser_valid  = r_ser_valid;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_pipeline_probe.sv
// Directed bench for pipeline_probe (WIDTH=8, CHANNELS=4); frame expectations follow PROBE_PARITY_EN.
module tb_pipeline_probe;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 4;
    localparam int CSEL_W   = 2;

`ifdef PROBE_PARITY_EN
    localparam int FLEN = 12;
    localparam logic [11:0] F_A5 = {11'b11010100101, 1'b1};
    localparam logic [11:0] F_3C = {11'b10100111100, 1'b1};
    localparam logic [11:0] F_FF = {11'b10111111111, 1'b1};
    localparam logic [11:0] F_81 = {11'b10010000001, 1'b0};
`else
    localparam int FLEN = 11;
    localparam logic [11:0] F_A5 = {1'b0, 11'b11010100101};
    localparam logic [11:0] F_3C = {1'b0, 11'b10100111100};
    localparam logic [11:0] F_FF = {1'b0, 11'b10111111111};
    localparam logic [11:0] F_81 = {1'b0, 11'b10010000001};
`endif

    logic                      clk = 1'b0;
    logic                      reset;
    logic [CHANNELS*WIDTH-1:0] ch_data;
    logic [CSEL_W-1:0]         ch_sel;
    logic                      start;
    logic                      cont;
    logic                      ser_out;
    logic                      ser_valid;
    logic                      busy;
    logic                      frame_done;

    int n_cmp = 0;
    int n_err = 0;

    pipeline_probe #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
        .clk        (clk),
        .reset      (reset),
        .ch_data    (ch_data),
        .ch_sel     (ch_sel),
        .start      (start),
        .cont       (cont),
        .ser_out    (ser_out),
        .ser_valid  (ser_valid),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic bit_cyc(input string tag, input logic b);
        chk({tag, " ser_out"}, ser_out, b);
        chk({tag, " ser_valid"}, ser_valid, 1'b1);
        chk({tag, " busy"}, busy, 1'b1);
        chk({tag, " frame_done"}, frame_done, 1'b0);
        tick();
    endtask

    task automatic gap_cyc(input string tag);
        chk({tag, " gap ser_out"}, ser_out, 1'b0);
        chk({tag, " gap ser_valid"}, ser_valid, 1'b0);
        chk({tag, " gap frame_done"}, frame_done, 1'b1);
        chk({tag, " gap busy"}, busy, 1'b1);
        tick();
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, " idle busy"}, busy, 1'b0);
        chk({tag, " idle ser_valid"}, ser_valid, 1'b0);
        chk({tag, " idle ser_out"}, ser_out, 1'b0);
        chk({tag, " idle frame_done"}, frame_done, 1'b0);
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b1;
        cont    = 1'b1;
        ch_data = 32'h1234_5678;
        ch_sel  = 2'd1;

        // Reset held for two edges, overriding start/cont.
        tick();
        tick();
        reset = 1'b0;
        start = 1'b0;
        cont  = 1'b0;
        idle_chk("reset");

        // Basic frame: ch2=A5, start at first edge after reset release.
        ch_data = {8'h00, 8'hA5, 8'h00, 8'h00};
        ch_sel  = 2'd2;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < FLEN; i++) bit_cyc("a5", F_A5[FLEN-1-i]);
        gap_cyc("a5");
        idle_chk("a5 end");

        // Start while busy is ignored; data/select changes do not disturb the frame.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < FLEN; i++) begin
            if (i == 3) start = 1'b1;
            if (i == 4) begin
                start   = 1'b0;
                ch_data = '0;
                ch_sel  = 2'd0;
            end
            bit_cyc("busy_start", F_A5[FLEN-1-i]);
        end
        gap_cyc("busy_start");
        idle_chk("busy_start end");
        tick();
        tick();
        idle_chk("busy_start no_requeue");

        // Continuous mode: second frame recaptures updated ch1, cont dropped mid-frame.
        ch_data = {8'h00, 8'h00, 8'h3C, 8'h00};
        ch_sel  = 2'd1;
        cont    = 1'b1;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < FLEN; i++) begin
            if (i == 5) ch_data[15:8] = 8'hFF;
            bit_cyc("cont f1", F_3C[FLEN-1-i]);
        end
        gap_cyc("cont f1");
        for (int i = 0; i < FLEN; i++) begin
            if (i == 2) cont = 1'b0;
            bit_cyc("cont f2", F_FF[FLEN-1-i]);
        end
        gap_cyc("cont f2");
        idle_chk("cont end");

        // Reset mid-frame, then a fresh frame.
        ch_data = {8'h00, 8'hA5, 8'h00, 8'h00};
        ch_sel  = 2'd2;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) bit_cyc("rst_mid", F_A5[FLEN-1-i]);
        reset = 1'b1;
        chk("rst_mid c5 ser_out", ser_out, F_A5[FLEN-5]);
        tick();
        reset = 1'b0;
        idle_chk("rst_mid c6");
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < FLEN; i++) bit_cyc("rst_after", F_A5[FLEN-1-i]);
        gap_cyc("rst_after");
        idle_chk("rst_after end");

        // Channel 0 with edge bits set in the data word.
        ch_data = {8'hFF, 8'hFF, 8'hFF, 8'h81};
        ch_sel  = 2'd0;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < FLEN; i++) bit_cyc("ch0_81", F_81[FLEN-1-i]);
        gap_cyc("ch0_81");
        idle_chk("ch0_81 end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_probe.md
PIPELINE_PROBE -- requirements
Module: pipeline_probe

Interface
REQ-001 Parameter WIDTH, default 32: bit width of each probed channel.
REQ-002 Parameter CHANNELS, default 2: number of probed channels; CSEL_W = max(1, clog2(CHANNELS)).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ch_data  input  CHANNELS*WIDTH  flattened channel words; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-006 ch_sel  input  CSEL_W  channel to capture.
REQ-007 start  input  1  frame request, sampled only in IDLE.
REQ-008 cont  input  1  continuous mode: re-arm automatically after each frame.
REQ-009 ser_out  output  1  serial frame bit, MSB first.
REQ-010 ser_valid  output  1  high while ser_out carries a frame bit.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 frame_done  output  1  one-cycle pulse in the GAP cycle.

Function
REQ-013 States: IDLE, MARK, CHAN, DATA, PAR, GAP; PAR exists only when PROBE_PARITY_EN is defined.
REQ-014 IDLE with start=1 at an edge: capture ch_sel into chan_q and the selected channel word into shift register; next state MARK.
REQ-015 ch_sel >= CHANNELS: captured data is all zeros; chan_q holds ch_sel as given.
REQ-016 MARK: ser_out=1 for one cycle.
REQ-017 CHAN: ser_out = chan_q, CSEL_W cycles, MSB first; CHANNELS=1 sends a single 0.
REQ-018 DATA: ser_out = captured word, WIDTH cycles, MSB first; bit counter and shift register are internal.
REQ-019 GAP: ser_out=0, ser_valid=0, frame_done=1, one cycle.
REQ-020 From GAP: cont=1 -> recapture ch_sel/ch_data at that edge, next state MARK; cont=0 -> IDLE.
REQ-021 Latency: start accepted at edge t -> MARK bit visible from t+1; frame length 1+CSEL_W+WIDTH bits (+1 with parity), then 1 GAP cycle.
REQ-022 ser_valid=1 in MARK, CHAN, DATA, PAR; 0 in IDLE and GAP; ser_out=0 whenever ser_valid=0.
REQ-023 start while busy ignored, not queued.
REQ-024 Changes to ch_data, ch_sel during a frame do not affect the frame in flight.
REQ-025 cont deasserted mid-frame: current frame completes; IDLE after GAP.
REQ-026 start and cont both high in IDLE: frame starts; continuous repetition follows while cont stays high.

Reset
REQ-027 reset=1 at an edge forces IDLE, ser_out=0, ser_valid=0, busy=0, frame_done=0, clears counters, chan_q and shift register; overrides all other inputs including mid-frame.
REQ-028 First start is accepted at the first edge after reset deasserts.

Configuration
REQ-029 Macro PROBE_PARITY_EN defined: PAR state after DATA, one cycle, ser_out = even parity over CHAN and DATA bits (marker excluded), so XOR of those bits and the parity bit is 0.
REQ-030 Macro undefined: no PAR state, no parity logic; DATA goes directly to GAP.

Verification (bench: WIDTH=8, CHANNELS=4, CSEL_W=2)
REQ-031 Assert reset 2 cycles -> ser_out=0, ser_valid=0, busy=0, frame_done=0 on the cycle after reset.
REQ-032 ch2=0xA5, ch_sel=2, start pulse at edge 0 -> cycles 1..11 ser_out=1,1,0,1,0,1,0,0,1,0,1, ser_valid=1; cycle 12 ser_out=0, frame_done=1; busy=0 at cycle 13.
REQ-033 Same frame, start pulsed at cycle 4 and ch2 changed to 0x00 at cycle 5 -> serial bits unchanged from REQ-032; no second frame.
REQ-034 cont=1, ch_sel=1, ch1=0x3C, start at edge 0; ch1 set to 0xFF at cycle 6 -> frame 1 data 0x3C, MARK of frame 2 at cycle 13 carrying 0xFF; cont dropped at cycle 15 -> frame 2 completes, busy=0 at cycle 25.
REQ-035 Reset pulsed at cycle 5 of a frame -> cycle 6 ser_out=0, busy=0; start at cycle 8 produces full frame from cycle 9 onward.
REQ-036 PROBE_PARITY_EN defined, REQ-032 stimulus -> cycle 12 parity bit=1, frame_done at cycle 13, busy=0 at cycle 14.
